// File: rtl/tile_display_scanner_if.sv
// Game-core address/data bus and SPI display pins of tile_display_scanner.
// The master side is the scanner; the slave side is the game core plus the panel.
interface tile_display_scanner_if;
    logic [2:0] row;
    logic [9:0] col;
    logic [7:0] data;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       dc;

    modport master (output row, col, sclk, mosi, cs_n, dc, input data);
    modport slave  (input row, col, sclk, mosi, cs_n, dc, output data);
endinterface

// File: rtl/tile_display_scanner.sv
// Streams the 8-page tile frame to an SSD1306-style panel over write-only SPI (mode 0).
// Optional build macro TILE_SCAN_INVERT_EN inverts every data byte (never command bytes).
module tile_display_scanner #(
    parameter int NUM_COLS = 128,
    parameter int COL_STEP = 8,
    parameter int CLK_DIV  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    tile_display_scanner_if.master        disp,
    output logic                          frame_done,
    output logic                          busy
);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  CMD   = 2'd1;
    localparam logic [1:0]  LOAD  = 2'd2;
    localparam logic [1:0]  SHIFT = 2'd3;
    localparam logic [15:0] DIV_MAX  = 16'(CLK_DIV - 1);
    localparam logic [10:0] LAST_COL = 11'(NUM_COLS - 1);
    localparam logic [9:0]  STEP     = 10'(COL_STEP);

    logic [1:0]  state_q, state_d;
    logic [2:0]  page_q, page_d;
    logic [1:0]  cmd_idx_q, cmd_idx_d;
    logic [10:0] col_idx_q, col_idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        dc_q, dc_d;
    logic [2:0]  row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;

    logic        start_cmd;
    logic [2:0]  start_page;
    logic [7:0]  next_cmd;
    logic [7:0]  load_byte;

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [2:0] pg);
        case (idx)
            2'd0:    return 8'hB0 | {5'd0, pg};
            2'd1:    return 8'h00;
            default: return 8'h10;
        endcase
    endfunction

`ifdef TILE_SCAN_INVERT_EN
    assign load_byte = disp.data ^ 8'hFF;
`else
    assign load_byte = disp.data;
`endif

    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        cmd_idx_d    = cmd_idx_q;
        col_idx_d    = col_idx_q;
        bit_d        = bit_q;
        div_d        = div_q;
        shreg_d      = shreg_q;
        sclk_d       = sclk_q;
        mosi_d       = mosi_q;
        cs_n_d       = cs_n_q;
        dc_d         = dc_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        start_cmd    = 1'b0;
        start_page   = 3'd0;
        next_cmd     = cmd_byte(cmd_idx_q + 2'd1, page_q);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    start_cmd  = 1'b1;
                    start_page = 3'd0;
                end
            end
            LOAD: begin
                shreg_d = load_byte;
                mosi_d  = load_byte[7];
                div_d   = 16'd0;
                bit_d   = 3'd0;
                state_d = SHIFT;
            end
            default: begin
                if (div_q != DIV_MAX) begin
                    div_d = div_q + 16'd1;
                end else begin
                    div_d  = 16'd0;
                    sclk_d = ~sclk_q;
                    // Falling edge: present the next bit, or finish the byte
                    if (sclk_q && bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                        mosi_d  = shreg_q[6];
                    end else if (sclk_q) begin
                        bit_d = 3'd0;
                        if (state_q == CMD) begin
                            if (cmd_idx_q != 2'd2) begin
                                cmd_idx_d = cmd_idx_q + 2'd1;
                                shreg_d   = next_cmd;
                                mosi_d    = next_cmd[7];
                            end else begin
                                state_d   = LOAD;
                                dc_d      = 1'b1;
                                col_idx_d = 11'd0;
                                col_d     = 10'd0;
                            end
                        end else if (col_idx_q != LAST_COL) begin
                            col_idx_d = col_idx_q + 11'd1;
                            col_d     = col_q + STEP;
                            state_d   = LOAD;
                        end else if (page_q != 3'd7) begin
                            start_cmd  = 1'b1;
                            start_page = page_q + 3'd1;
                        end else begin
                            frame_done_d = 1'b1;
                            if (enable) begin
                                start_cmd  = 1'b1;
                                start_page = 3'd0;
                            end else begin
                                state_d = IDLE;
                                page_d  = 3'd0;
                                cs_n_d  = 1'b1;
                                dc_d    = 1'b0;
                                mosi_d  = 1'b0;
                                row_d   = 3'd0;
                                col_d   = 10'd0;
                            end
                        end
                    end
                end
            end
        endcase

        // Page preamble start; cs_n stays low across page boundaries
        if (start_cmd) begin
            state_d   = CMD;
            page_d    = start_page;
            row_d     = start_page;
            col_d     = 10'd0;
            col_idx_d = 11'd0;
            cmd_idx_d = 2'd0;
            shreg_d   = cmd_byte(2'd0, start_page);
            mosi_d    = 1'b1;
            cs_n_d    = 1'b0;
            dc_d      = 1'b0;
            sclk_d    = 1'b0;
            div_d     = 16'd0;
            bit_d     = 3'd0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            page_q       <= 3'd0;
            cmd_idx_q    <= 2'd0;
            col_idx_q    <= 11'd0;
            bit_q        <= 3'd0;
            div_q        <= 16'd0;
            shreg_q      <= 8'd0;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            dc_q         <= 1'b0;
            row_q        <= 3'd0;
            col_q        <= 10'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            cmd_idx_q    <= cmd_idx_d;
            col_idx_q    <= col_idx_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            dc_q         <= dc_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign disp.row   = row_q;
    assign disp.col   = col_q;
    assign disp.sclk  = sclk_q;
    assign disp.mosi  = mosi_q;
    assign disp.cs_n  = cs_n_q;
    assign disp.dc    = dc_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_tile_display_scanner.sv
// Bench for tile_display_scanner: an SPI receiver collects bytes, then vectors and sequences are checked.
// Expected data bytes follow the TILE_SCAN_INVERT_EN build setting.
module tb_tile_display_scanner;
    localparam int CLK_DIV   = 2;
    localparam int PAGE_B    = 131;
    localparam int FRAME_CYC = 34560;

    typedef struct packed {
        logic [7:0] b;
        logic       dc;
        logic [2:0] row;
        logic [9:0] col;
        logic       addr_bad;
    } rx_t;

    typedef struct {
        int         k;
        logic [7:0] b;
        logic       dc;
    } vec_t;

    logic clk;
    logic rst_n;
    logic enable;
    logic frame_done;
    logic busy;
    logic mode;
    logic [7:0] data_const;

    tile_display_scanner_if u_if ();

    tile_display_scanner #(.NUM_COLS(128), .COL_STEP(8), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .disp       (u_if),
        .frame_done (frame_done),
        .busy       (busy)
    );

    assign u_if.data = mode ? {u_if.row, u_if.col[9:5]} : data_const;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    rx_t  mon_q[$];
    int   mon_bits = 0;
    int   cyc = 0;
    int   rise_cnt = 0;
    int   fd_cnt = 0;
    int   fd_cyc = 0;
    int   cs_fall_cyc = 0;
    int   stab_err = 0;
    logic stab_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [7:0] b);
`ifdef TILE_SCAN_INVERT_EN
        return b ^ 8'hFF;
`else
        return b;
`endif
    endfunction

    // SPI receiver: samples on sclk rising edges, checked on the falling clk edge
    initial begin
        logic [7:0] shv;
        logic       dcv;
        logic [2:0] r0;
        logic [9:0] c0;
        logic       abad;
        logic       sclk_p;
        logic       mosi_p;
        logic       cs_p;
        int         run;
        shv = 8'd0; dcv = 1'b0; r0 = 3'd0; c0 = 10'd0; abad = 1'b0;
        sclk_p = 1'b0; mosi_p = 1'b0; cs_p = 1'b1; run = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (u_if.sclk && !sclk_p) rise_cnt++;
            if (!rst_n || u_if.cs_n) begin
                mon_bits = 0;
                abad = 1'b0;
            end else if (u_if.sclk && !sclk_p) begin
                if (mon_bits == 0) begin
                    r0 = u_if.row; c0 = u_if.col; dcv = u_if.dc; abad = 1'b0;
                end else if (u_if.row != r0 || u_if.col != c0) begin
                    abad = 1'b1;
                end
                shv = {shv[6:0], u_if.mosi};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_q.push_back('{b: shv, dc: dcv, row: r0, col: c0, addr_bad: abad});
                    mon_bits = 0;
                end
            end
            if (stab_en && sclk_p && !u_if.sclk && run < 2 * CLK_DIV) stab_err++;
            run = (u_if.mosi == mosi_p) ? run + 1 : 1;
            if (rst_n && cs_p && !u_if.cs_n) cs_fall_cyc = cyc;
            if (frame_done) begin
                if (fd_cnt == 0) fd_cyc = cyc;
                fd_cnt++;
            end
            sclk_p = u_if.sclk;
            mosi_p = u_if.mosi;
            cs_p   = u_if.cs_n;
        end
    end

    task automatic wait_q(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (mon_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_reached"}, 32'(mon_q.size() >= n), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, 32'(u_if.cs_n), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sclk"}, 32'(u_if.sclk), 32'd0);
        chk({tag, "_mosi"}, 32'(u_if.mosi), 32'd0);
        chk({tag, "_dc"}, 32'(u_if.dc), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_row"}, 32'(u_if.row), 32'd0);
        chk({tag, "_col"}, 32'(u_if.col), 32'd0);
    endtask

    initial begin
        vec_t tbl[14];
        int   c;
        int   walk_err;
        int   rises0;
        int   diff;
        tbl[0]  = '{0,    8'hB0, 1'b0};
        tbl[1]  = '{1,    8'h00, 1'b0};
        tbl[2]  = '{2,    8'h10, 1'b0};
        tbl[3]  = '{3,    8'h00, 1'b1};
        tbl[4]  = '{7,    8'h01, 1'b1};
        tbl[5]  = '{130,  8'h1F, 1'b1};
        tbl[6]  = '{131,  8'hB1, 1'b0};
        tbl[7]  = '{134,  8'h20, 1'b1};
        tbl[8]  = '{261,  8'h3F, 1'b1};
        tbl[9]  = '{393,  8'hB3, 1'b0};
        tbl[10] = '{917,  8'hB7, 1'b0};
        tbl[11] = '{920,  8'hE0, 1'b1};
        tbl[12] = '{1043, 8'hFE, 1'b1};
        tbl[13] = '{1047, 8'hFF, 1'b1};

        rst_n = 1'b0; enable = 1'b1; mode = 1'b0; data_const = 8'hA5;
        repeat (5) @(negedge clk);
        chk_reset_outputs("hold_rst");

        // First frame start with constant data
        rst_n = 1'b1;
        stab_en = 1'b1;
        wait_q(4, 600, "first4");
        if (mon_q.size() >= 4) begin
            chk("byte0", 32'({mon_q[0].b, mon_q[0].dc}), 32'({8'hB0, 1'b0}));
            chk("byte1", 32'({mon_q[1].b, mon_q[1].dc}), 32'({8'h00, 1'b0}));
            chk("byte2", 32'({mon_q[2].b, mon_q[2].dc}), 32'({8'h10, 1'b0}));
            chk("byte3", 32'({mon_q[3].b, mon_q[3].dc}), 32'({exp_data(8'hA5), 1'b1}));
            chk("byte3_row", 32'(mon_q[3].row), 32'd0);
            chk("byte3_col", 32'(mon_q[3].col), 32'd0);
            chk("byte3_addr_stable", 32'(mon_q[3].addr_bad), 32'd0);
        end

        // Reset in the middle of the next data byte
        c = 0;
        while (!(mon_bits == 4 && u_if.dc == 1'b1) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("midbyte_reached", 32'(c < 200), 32'd1);
        chk("bit_stable", 32'(stab_err), 32'd0);
        stab_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_rst");

        // Full frame with address model; enable dropped during page 3
        repeat (3) @(negedge clk);
        mon_q.delete();
        fd_cnt = 0;
        mode = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_q(3 * PAGE_B + 5, 20000, "page3");
        enable = 1'b0;
        c = 0;
        while (fd_cnt == 0 && c < 40000) begin
            @(negedge clk);
            c++;
        end
        chk("frame_done_seen", 32'(fd_cnt > 0), 32'd1);
        repeat (2) @(negedge clk);
        chk("end_cs_n", 32'(u_if.cs_n), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        rises0 = rise_cnt;
        repeat (100) @(negedge clk);
        chk("no_more_sclk", 32'(rise_cnt - rises0), 32'd0);
        chk("frame_done_once", 32'(fd_cnt), 32'd1);
        diff = fd_cyc - cs_fall_cyc;
        chk("frame_time", 32'(diff >= FRAME_CYC - 1 && diff <= FRAME_CYC + 1), 32'd1);
        chk("frame_bytes", 32'(mon_q.size()), 32'(8 * PAGE_B));

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].k < mon_q.size()) begin
                chk($sformatf("vec_k%0d", tbl[i].k),
                    32'({mon_q[tbl[i].k].b, mon_q[tbl[i].k].dc}),
                    32'({tbl[i].dc ? exp_data(tbl[i].b) : tbl[i].b, tbl[i].dc}));
            end else begin
                chk($sformatf("vec_k%0d_present", tbl[i].k), 32'd0, 32'd1);
            end
        end

        walk_err = 0;
        for (int k = 0; k < mon_q.size() && k < 8 * PAGE_B; k++) begin
            logic [2:0] pg;
            logic [6:0] idx;
            logic [7:0] eb;
            int         j;
            pg = 3'(k / PAGE_B);
            j  = k % PAGE_B;
            if (j < 3) begin
                eb = (j == 0) ? (8'hB0 | {5'd0, pg}) : ((j == 1) ? 8'h00 : 8'h10);
                if (mon_q[k].b != eb || mon_q[k].dc != 1'b0 || mon_q[k].row != pg) walk_err++;
            end else begin
                idx = 7'(j - 3);
                eb  = exp_data({pg, idx[6:2]});
                if (mon_q[k].b != eb || mon_q[k].dc != 1'b1 || mon_q[k].row != pg ||
                    mon_q[k].col != {idx, 3'b000} || mon_q[k].addr_bad) walk_err++;
            end
        end
        chk("walk_all_bytes", 32'(walk_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
